// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port plus valid/ready stream; m_last exists only with FSR_PKT_LAST_EN
interface fifo_stream_reader_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  fifo_rd_en;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
`ifdef FSR_PKT_LAST_EN
   logic                  m_last;
   modport master (input fifo_empty, fifo_dout, m_ready, output fifo_rd_en, m_valid, m_data, m_last);
   modport slave (output fifo_empty, fifo_dout, m_ready, input fifo_rd_en, m_valid, m_data, m_last);
`else
   modport master (input fifo_empty, fifo_dout, m_ready, output fifo_rd_en, m_valid, m_data);
   modport slave (output fifo_empty, fifo_dout, m_ready, input fifo_rd_en, m_valid, m_data);
`endif
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a sync FIFO read port into a valid/ready stream via a 2-entry skid buffer.
// Optional FSR_PKT_LAST_EN adds m_last and a beat counter marking every PKT_LEN-th word.
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
`ifdef FSR_PKT_LAST_EN
   ,
   parameter int PKT_LEN    = 4
`endif
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fifo_stream_reader_if.master bus,
   output logic [CNT_WIDTH-1:0] word_cnt
);
   logic [1:0]            occ, occ_nxt, kept;
   logic                  inflight, pop;
   logic [DATA_WIDTH-1:0] head, tail, head_nxt, tail_nxt;

   assign pop            = bus.m_valid && bus.m_ready;
   assign kept           = occ - {1'b0, pop};
   assign occ_nxt        = kept + {1'b0, inflight};
   assign bus.fifo_rd_en = rst_n && !bus.fifo_empty && !occ_nxt[1];
   assign bus.m_valid    = occ != 2'd0;
   assign bus.m_data     = head;

   // A pop shifts tail into head; the landing word fills the first slot left free after the pop.
   always_comb begin
      head_nxt = (inflight && kept == 2'd0) ? bus.fifo_dout : pop ? tail : head;
      tail_nxt = (inflight && kept == 2'd1) ? bus.fifo_dout : tail;
   end

   // Buffer entries, occupancy, read-latency tracker and delivered-word counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ      <= '0;
         inflight <= 1'b0;
         head     <= '0;
         tail     <= '0;
         word_cnt <= '0;
      end else begin
         occ      <= occ_nxt;
         inflight <= bus.fifo_rd_en;
         head     <= head_nxt;
         tail     <= tail_nxt;
         word_cnt <= pop ? word_cnt + CNT_WIDTH'(1) : word_cnt;
      end
   end

`ifdef FSR_PKT_LAST_EN
   localparam int BW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;

   logic [BW-1:0] beat;
   logic          last_beat;

   assign last_beat  = beat == BW'(PKT_LEN - 1);
   assign bus.m_last = bus.m_valid && last_beat;

   // Position within the packet, advanced once per delivered word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) beat <= '0;
      else if (pop) beat <= last_beat ? '0 : beat + BW'(1);
   end
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed and randomized bench against a count-based model of the stream rules.
module tb_fifo_stream_reader;
   localparam int DW = 8;
   localparam int CW = 4;
`ifdef FSR_PKT_LAST_EN
   localparam int PL = 4;
`endif

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic [CW-1:0] word_cnt;

   fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

   fifo_stream_reader #(
      .DATA_WIDTH(DW),
      .CNT_WIDTH (CW)
`ifdef FSR_PKT_LAST_EN
      ,
      .PKT_LEN   (PL)
`endif
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   int            total = 0, bad = 0;
   int            n_rd = 0, n_pop = 0, cyc = 0;
   bit            last_rd = 0, ready_q = 0, rst_q = 1, cur_rd = 0;
   logic [DW-1:0] src[$], sent[$], got[$];
`ifdef FSR_PKT_LAST_EN
   logic [DW-1:0] lasts[$];
`endif

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [DW-1:0] w);
      src.push_back(w);
      sent.push_back(w);
   endtask

   // One clock: the FIFO model answers last edge's read, inputs change, outputs are checked
   // against the counts of reads issued and words delivered, then this cycle's events are recorded.
   task automatic step();
      int avail;
      bit ev, epop, erd, apop;
      @(negedge clk);
      cyc++;
      if (last_rd) bus.fifo_dout = src.pop_front();
      rst_n = !rst_q;
      if (rst_q) begin
         sent    = src;
         n_rd    = 0;
         n_pop   = 0;
         last_rd = 0;
      end
      bus.m_ready    = ready_q;
      bus.fifo_empty = src.size() == 0;
      #1;
      avail = n_rd - int'(last_rd) - n_pop;
      ev    = rst_n && avail > 0;
      epop  = ev && ready_q;
      erd   = rst_n && !bus.fifo_empty && (n_rd - n_pop - int'(epop)) < 2;
      chk("m_valid", int'(bus.m_valid), int'(ev));
      if (ev) chk("m_data", int'(bus.m_data), int'(sent[n_pop]));
      chk("fifo_rd_en", int'(bus.fifo_rd_en), int'(erd));
      chk("word_cnt", int'(word_cnt), n_pop % (1 << CW));
`ifdef FSR_PKT_LAST_EN
      chk("m_last", int'(bus.m_last), int'(ev && (n_pop % PL == PL - 1)));
`endif
      apop   = bus.m_valid && ready_q;
      cur_rd = bus.fifo_rd_en;
      if (apop) got.push_back(bus.m_data);
`ifdef FSR_PKT_LAST_EN
      if (apop && bus.m_last) lasts.push_back(bus.m_data);
`endif
      n_rd    += int'(cur_rd);
      n_pop   += int'(apop);
      last_rd  = cur_rd;
      chk("read_ahead", int'(n_rd - n_pop <= 2), 1);
   endtask

   task automatic mid_reset();
      rst_n = 1'b0;
      #1;
      chk("rst m_valid", int'(bus.m_valid), 0);
      chk("rst word_cnt", int'(word_cnt), 0);
      chk("rst fifo_rd_en", int'(bus.fifo_rd_en), 0);
      sent    = src;
      n_rd    = 0;
      n_pop   = 0;
      last_rd = 0;
   endtask

   initial begin
      int first, lastp, k, rds;
      bus.fifo_empty = 1'b1;
      bus.fifo_dout  = '0;
      bus.m_ready    = 1'b0;
      #1 rst_n = 1'b0;
      push(8'hA5);
      push(8'h5A);
      repeat (3) step();
      chk("reset fifo_rd_en", int'(bus.fifo_rd_en), 0);
      chk("reset m_valid", int'(bus.m_valid), 0);
      chk("reset m_data", int'(bus.m_data), 0);
      chk("reset word_cnt", int'(word_cnt), 0);
      src.delete();
      sent.delete();
      rst_q   = 0;
      ready_q = 1;
      repeat (3) step();

      got.delete();
      for (int i = 1; i <= 4; i++) push(8'(i * 17));
      first = -1;
      lastp = -1;
      k     = cyc + 1;
      repeat (10) begin
         step();
         if (bus.m_valid && first < 0) first = cyc;
         if (bus.m_valid) lastp = cyc;
      end
      chk("first latency", first - k, 2);
      chk("burst span", lastp - first, 3);
      chk("stream word_cnt", int'(word_cnt), 4);
      chk("stream order", {got[0], got[1], got[2], got[3]}, 32'h11223344);

      got.delete();
      ready_q = 0;
      rds     = 0;
      for (int i = 1; i <= 4; i++) push(8'(i * 17));
      repeat (10) begin
         step();
         rds += int'(cur_rd);
      end
      chk("stall reads", rds, 2);
      chk("stall m_valid", int'(bus.m_valid), 1);
      chk("stall m_data", int'(bus.m_data), 8'h11);
      ready_q = 1;
      repeat (10) step();
      chk("stall order", {got[0], got[1], got[2], got[3]}, 32'h11223344);

      got.delete();
      for (int i = 1; i <= 32; i++) push(8'(i));
      repeat (80) begin
         ready_q = !ready_q;
         step();
      end
      k = 0;
      foreach (got[i]) if (got[i] == 8'(i + 1)) k++;
      chk("toggle count", got.size(), 32);
      chk("toggle order", k, 32);
      chk("toggle word_cnt", int'(word_cnt), 8);

      ready_q = 1;
      rds     = 0;
      repeat (10) begin
         step();
         rds += int'(cur_rd) + int'(bus.m_valid);
      end
      chk("empty idle", rds, 0);

      ready_q = 0;
      push(8'hA1);
      push(8'hA2);
      repeat (3) step();
      chk("pre-reset m_valid", int'(bus.m_valid), 1);
      chk("pre-reset m_data", int'(bus.m_data), 8'hA1);
      mid_reset();
      rst_q = 1;
      step();
      rst_q   = 0;
      ready_q = 1;
      repeat (3) step();

      got.delete();
      for (int i = 0; i < 17; i++) push(8'(i + 8'h30));
      repeat (25) step();
      chk("wrap count", got.size(), 17);
      chk("wrap word_cnt", int'(word_cnt), 1);

`ifdef FSR_PKT_LAST_EN
      rst_q = 1;
      step();
      rst_q = 0;
      lasts.delete();
      for (int i = 1; i <= 8; i++) push(8'(i * 17));
      repeat (14) step();
      chk("last count", lasts.size(), 2);
      chk("last words", {lasts[0], lasts[1]}, 16'h4488);
`endif

      repeat (3000) begin
         ready_q = $urandom_range(0, 9) < 7;
         if ($urandom_range(0, 3) != 0 && src.size() < 6) push(8'($urandom));
         rst_q = $urandom_range(0, 299) == 0;
         step();
      end
      rst_q = 0;
      repeat (20) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Downstream consumer stage of the synchronous FIFO. Drains the FIFO read port (rd_en/dout/empty) and presents the words as a valid/ready stream to the next block.
- Absorbs the FIFO's one-cycle registered read latency with a 2-entry skid buffer. Sustains one word per clock when the FIFO is non-empty and the sink is ready.
- Keeps a running count of delivered words.

Parameters:
DATA_WIDTH, 8, width of FIFO data and stream data
CNT_WIDTH, 16, width of the delivered-word counter
PKT_LEN, 4, words per packet; used only when FSR_PKT_LAST_EN is defined; must be >= 1

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
fifo_empty  input  1  FIFO empty flag
fifo_dout  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read
fifo_rd_en  output  1  FIFO read request
m_valid  output  1  stream word available
m_ready  input  1  sink accepts word
m_data  output  DATA_WIDTH  stream word
word_cnt  output  CNT_WIDTH  number of completed m_valid&&m_ready handshakes, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (rst_n low, async assert, sync-release use):
  - occ=0, inflight=0, buffer entries=0.
  - m_valid=0, m_data=0, word_cnt=0.
  - fifo_rd_en forced 0 while rst_n is low.
- State:
  - occ (0..2): number of buffered words.
  - inflight (0/1): a read was issued last cycle and its data lands this cycle.
- Read issue (combinational):
  - pop = m_valid && m_ready.
  - fifo_rd_en = rst_n && !fifo_empty && (occ + inflight - pop) < 2.
  - Combinational path m_ready -> fifo_rd_en is intentional and gives zero-bubble throughput.
- Each edge:
  - inflight <= fifo_rd_en.
  - If inflight, capture fifo_dout into the buffer tail.
  - If pop, remove the head.
  - occ <= occ + inflight - pop.
  - Push and pop in the same cycle are legal.
  - occ never exceeds 2. Exceeding 2 is a design error; the bench asserts it never happens.
- Output:
  - m_valid = (occ != 0). m_data = head entry, driven directly from a register.
  - Latency: first word reaches m_valid 2 cycles after fifo_empty deasserts (rd_en cycle, capture cycle).
- Stream rules:
  - Once m_valid is high, m_valid and m_data hold stable until the pop edge.
  - Words emerge in FIFO order; none are dropped or duplicated.
- Empty: when fifo_empty is high, fifo_rd_en=0. The buffer drains normally.
- Backpressure: with m_ready low, at most 2 words are read ahead (1 buffered + 1 inflight, or 2 buffered). Then fifo_rd_en stays 0.
- word_cnt increments by 1 per pop and wraps from all-ones to 0.
- Reset mid-operation: buffered and inflight words are discarded. All state returns to reset values immediately. The FIFO's own state is not affected by this block.

Optional Feature:
- Macro FSR_PKT_LAST_EN.
- Defined:
  - Adds output port m_last (1 bit) and an internal beat counter (0..PKT_LEN-1, reset 0).
  - m_last is high when m_valid is high and beat counter == PKT_LEN-1.
  - On each pop the beat counter increments, wrapping to 0 after the last beat.
  - m_last is stable while stalled. Reset clears the beat counter.
- Undefined: no m_last port, no beat counter. Behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 with fifo_empty=0 -> fifo_rd_en=0, m_valid=0, m_data=0x00, word_cnt=0.
- Streaming: DEPTH=4 FIFO preloaded with 0x11,0x22,0x33,0x44, m_ready=1 -> m_data 0x11..0x44 on 4 consecutive cycles, first m_valid 2 cycles after release, word_cnt=4, no gaps.
- Backpressure: same load, m_ready=0 for 10 cycles, then 1 -> exactly 2 fifo_rd_en pulses during the stall, m_data holds 0x11 stable, then order 0x11,0x22,0x33,0x44.
- Toggling ready: m_ready alternating 1/0 with a continuous feed of 0x01..0x20 -> all 32 words delivered in order, occ never >2, word_cnt=32.
- Empty: FIFO empty throughout with m_ready=1 -> fifo_rd_en never asserts, m_valid stays 0. Reset mid-stream with 1 word buffered and 1 inflight -> m_valid=0 next cycle, word_cnt=0.
- FSR_PKT_LAST_EN defined, PKT_LEN=4, 8 words 0x11..0x88 -> m_last high only on 0x44 and 0x88. Wrap case: CNT_WIDTH=4, 17 words -> word_cnt=1.
